// File: rtl/banco_registros_rv32.sv
// rtl/banco_registros_rv32.sv - RV32I integer register file, two async read ports, one sync write port
module banco_registros_rv32 #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] Add_A,
    input  logic [ADDR_W-1:0] Add_B,
    input  logic [ADDR_W-1:0] Add_Dest,
    input  logic [DATA_W-1:0] Write_Data,
    input  logic              Write_En,
    output logic [DATA_W-1:0] Info_A,
    output logic [DATA_W-1:0] Info_B
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [0:DEPTH-1];
    logic              write_ok;

    // x0 never accepts a write; reset takes priority over any write.
    assign write_ok = Write_En && (Add_Dest != '0);

    // Storage update: reset clears everything, otherwise a qualified write lands in rd.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (write_ok) begin
                regs[Add_Dest] <= Write_Data;
            end
            regs[0] <= '0;
        end
    end

    // Read ports: no bypass from the write port; address 0 is masked so it reads
    // zero even before the first reset has cleared the array.
    always_comb begin
        Info_A = (Add_A == '0) ? '0 : regs[Add_A];
        Info_B = (Add_B == '0) ? '0 : regs[Add_B];
    end

endmodule

// File: tb/tb_banco_registros_rv32.sv
// tb/tb_banco_registros_rv32.sv - directed self-checking bench for banco_registros_rv32
module tb_banco_registros_rv32;

    logic        CLK;
    logic        RST;
    logic [4:0]  Add_A;
    logic [4:0]  Add_B;
    logic [4:0]  Add_Dest;
    logic [31:0] Write_Data;
    logic        Write_En;
    logic [31:0] Info_A;
    logic [31:0] Info_B;

    int n_checks;
    int n_fail;

    banco_registros_rv32 #(.DATA_W(32), .ADDR_W(5)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Add_A      (Add_A),
        .Add_B      (Add_B),
        .Add_Dest   (Add_Dest),
        .Write_Data (Write_Data),
        .Write_En   (Write_En),
        .Info_A     (Info_A),
        .Info_B     (Info_B)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        Write_En = 1'b0;
        tick();
        RST = 1'b0;
        Add_A = 5'd5;
        Add_B = 5'd31;
        #1;
        n_checks++;
        if (Info_A !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_a: got %0h expected 0", Info_A);
        end
        n_checks++;
        if (Info_B !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_b: got %0h expected 0", Info_B);
        end
    endtask

    task automatic test_x0_write();
        Write_En = 1'b1;
        Add_Dest = 5'd0;
        Write_Data = 32'd30;
        tick();
        Write_En = 1'b0;
        Add_A = 5'd0;
        Add_B = 5'd0;
        #1;
        n_checks++;
        if (Info_A !== 32'd0) begin
            n_fail++;
            $display("FAIL x0_write_a: got %0h expected 0", Info_A);
        end
        n_checks++;
        if (Info_B !== 32'd0) begin
            n_fail++;
            $display("FAIL x0_write_b: got %0h expected 0", Info_B);
        end
    endtask

    task automatic test_write_read();
        logic [31:0] vals [4] = '{32'd20, 32'd25, 32'd5, 32'd8};
        for (int i = 0; i < 4; i++) begin
            Write_En = 1'b1;
            Add_Dest = 5'(i + 1);
            Write_Data = vals[i];
            tick();
        end
        Write_En = 1'b0;
        Add_A = 5'd3;
        Add_B = 5'd1;
        #1;
        n_checks++;
        if (Info_A !== 32'd5) begin
            n_fail++;
            $display("FAIL read_x3: got %0d expected 5", Info_A);
        end
        n_checks++;
        if (Info_B !== 32'd20) begin
            n_fail++;
            $display("FAIL read_x1: got %0d expected 20", Info_B);
        end
        Add_A = 5'd2;
        Add_B = 5'd0;
        #1;
        n_checks++;
        if (Info_A !== 32'd25) begin
            n_fail++;
            $display("FAIL read_x2: got %0d expected 25", Info_A);
        end
        n_checks++;
        if (Info_B !== 32'd0) begin
            n_fail++;
            $display("FAIL read_x0: got %0d expected 0", Info_B);
        end
        Add_A = 5'd4;
        #1;
        n_checks++;
        if (Info_A !== 32'd8) begin
            n_fail++;
            $display("FAIL read_x4: got %0d expected 8", Info_A);
        end
    endtask

    task automatic test_write_disabled();
        Write_En = 1'b0;
        Add_Dest = 5'd2;
        Write_Data = 32'd99;
        tick();
        Add_A = 5'd2;
        #1;
        n_checks++;
        if (Info_A !== 32'd25) begin
            n_fail++;
            $display("FAIL write_disabled: got %0d expected 25", Info_A);
        end
    endtask

    task automatic test_read_during_write();
        Write_En = 1'b1;
        Add_Dest = 5'd7;
        Write_Data = 32'd4;
        Add_A = 5'd7;
        Add_B = 5'd7;
        #1;
        n_checks++;
        if (Info_A !== 32'd0) begin
            n_fail++;
            $display("FAIL rdw_before_a: got %0d expected 0", Info_A);
        end
        n_checks++;
        if (Info_B !== 32'd0) begin
            n_fail++;
            $display("FAIL rdw_before_b: got %0d expected 0", Info_B);
        end
        tick();
        Write_En = 1'b0;
        n_checks++;
        if (Info_A !== 32'd4) begin
            n_fail++;
            $display("FAIL rdw_after_a: got %0d expected 4", Info_A);
        end
        n_checks++;
        if (Info_B !== 32'd4) begin
            n_fail++;
            $display("FAIL rdw_after_b: got %0d expected 4", Info_B);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] seq [3] = '{32'h1111_0001, 32'h2222_0002, 32'hDEAD_BEEF};
        Add_A = 5'd9;
        Add_B = 5'd3;
        for (int i = 0; i < 3; i++) begin
            Write_En = 1'b1;
            Add_Dest = 5'd9;
            Write_Data = seq[i];
            tick();
            n_checks++;
            if (Info_A !== seq[i]) begin
                n_fail++;
                $display("FAIL back_to_back_%0d: got %0h expected %0h", i, Info_A, seq[i]);
            end
        end
        Write_En = 1'b0;
        tick();
        n_checks++;
        if (Info_A !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL back_to_back_hold: got %0h expected deadbeef", Info_A);
        end
        n_checks++;
        if (Info_B !== 32'd5) begin
            n_fail++;
            $display("FAIL back_to_back_neighbour: got %0d expected 5", Info_B);
        end
    endtask

    task automatic test_reset_priority();
        RST = 1'b1;
        Write_En = 1'b1;
        Add_Dest = 5'd3;
        Write_Data = 32'd77;
        tick();
        RST = 1'b0;
        Write_En = 1'b0;
        Add_A = 5'd3;
        Add_B = 5'd9;
        #1;
        n_checks++;
        if (Info_A !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_priority_x3: got %0d expected 0", Info_A);
        end
        n_checks++;
        if (Info_B !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_priority_x9: got %0h expected 0", Info_B);
        end
    endtask

    function automatic logic [31:0] pattern(int idx);
        return (32'(idx) * 32'h0101_0101) ^ 32'hA5A5_5A5A;
    endfunction

    task automatic test_all_regs();
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        for (int i = 0; i < 32; i++) begin
            Write_En = 1'b1;
            Add_Dest = 5'(i);
            Write_Data = pattern(i);
            tick();
        end
        Write_En = 1'b0;
        for (int i = 0; i < 32; i++) begin
            Add_A = 5'(i);
            Add_B = 5'(31 - i);
            exp_a = (i == 0) ? 32'd0 : pattern(i);
            exp_b = (i == 31) ? 32'd0 : pattern(31 - i);
            #1;
            n_checks++;
            if (Info_A !== exp_a) begin
                n_fail++;
                $display("FAIL all_regs_a[%0d]: got %0h expected %0h", i, Info_A, exp_a);
            end
            n_checks++;
            if (Info_B !== exp_b) begin
                n_fail++;
                $display("FAIL all_regs_b[%0d]: got %0h expected %0h", 31 - i, Info_B, exp_b);
            end
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        for (int i = 0; i < 32; i++) begin
            Add_A = 5'(i);
            Add_B = 5'(i);
            #1;
            n_checks++;
            if (Info_A !== 32'd0 || Info_B !== 32'd0) begin
                n_fail++;
                $display("FAIL all_regs_cleared[%0d]: got %0h/%0h expected 0", i, Info_A, Info_B);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        RST = 1'b0;
        Add_A = '0;
        Add_B = '0;
        Add_Dest = '0;
        Write_Data = '0;
        Write_En = 1'b0;
        #2;
        test_reset();
        test_x0_write();
        test_write_read();
        test_write_disabled();
        test_read_during_write();
        test_back_to_back();
        test_reset_priority();
        test_all_regs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
